// File: rtl/mc_burst_ctrl.sv
// mc_burst_ctrl: one page of burst memory on the multiplexed address/data bus.
//
// Owns page PAGE_ID (ad_in[DATA_W-1 -: PAGE_BITS]) and serves fixed-length
// BURST_LEN read/write bursts out of a private 2^ADDR_W x DATA_W array. Burst
// addresses wrap inside the aligned BURST_LEN block of the start offset.
//
// Ports:
//   clk        system clock, rising edge
//   resetL     asynchronous active-low reset
//   addr_valid address cycle strobe from the primary
//   rw         1 = read, 0 = write (sampled with addr_valid)
//   ad_in      address on the address cycle, write data afterwards
//   ad_out     registered read data; holds its value while ad_oe = 0
//   ad_oe      ad_out carries a valid read word
//   busy       a burst is in progress in this instance
//   rd_bursts  accepted read bursts, saturating (MC_STATS_EN only)
//   wr_bursts  accepted write bursts, saturating (MC_STATS_EN only)
//
// Optional feature macro: MC_STATS_EN adds the rd_bursts/wr_bursts counters.
module mc_burst_ctrl #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PAGE_BITS = 4,
  parameter int unsigned PAGE_ID   = 0,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              resetL,
  input  logic              addr_valid,
  input  logic              rw,
  input  logic [DATA_W-1:0] ad_in,
`ifdef MC_STATS_EN
  output logic [15:0]       rd_bursts,
  output logic [15:0]       wr_bursts,
`endif
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              busy
);

  localparam int unsigned ADDR_W = DATA_W - PAGE_BITS;
  localparam int unsigned CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned Depth  = 32'd1 << ADDR_W;

  localparam logic [ADDR_W-1:0]    WrapMask = ADDR_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]     LastCnt  = CNT_W'(BURST_LEN - 1);
  localparam logic [PAGE_BITS-1:0] PageSel  = PAGE_BITS'(PAGE_ID);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] offset_q, offset_d;

  logic [DATA_W-1:0] mem [Depth];

  logic              page_hit;
  logic              last_beat;
  logic              accept;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] new_offset;

  // Word k of a burst: block bits from the start offset, low bits advance
  // modulo BURST_LEN. With BURST_LEN = 1 the mask is zero and this is a no-op.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [CNT_W-1:0]  k);
    logic [ADDR_W-1:0] sum;
    sum = base + ADDR_W'(k);
    return (base & ~WrapMask) | (sum & WrapMask);
  endfunction

  assign page_hit   = addr_valid && (ad_in[DATA_W-1 -: PAGE_BITS] == PageSel);
  assign new_offset = ad_in[ADDR_W-1:0];
  assign last_beat  = (cnt_q == LastCnt);
  assign wr_addr    = burst_addr(offset_q, cnt_q);

  // cnt_q is the index of the word on the bus (read) or being written (write).
  // A new address is taken in IDLE or on the edge that finishes a burst, so
  // consecutive bursts run with no gap.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    accept   = 1'b0;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    rd_addr  = offset_q;

    unique case (state_q)
      StIdle: accept = page_hit;
      StRead: begin
        if (last_beat) begin
          state_d = StIdle;
          accept  = page_hit;
        end else begin
          rd_en   = 1'b1;
          rd_addr = burst_addr(offset_q, cnt_q + 1'b1);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StWrite: begin
        wr_en = 1'b1;
        if (last_beat) begin
          state_d = StIdle;
          accept  = page_hit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      offset_d = new_offset;
      cnt_d    = '0;
      state_d  = rw ? StRead : StWrite;
      // Word 0 is fetched on the address edge to give one-cycle read latency.
      if (rw) begin
        rd_en   = 1'b1;
        rd_addr = new_offset;
      end
    end
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      offset_q <= '0;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      ad_oe    <= (state_d == StRead);
      busy     <= (state_d != StIdle);
      if (rd_en) begin
        ad_out <= mem[rd_addr];
      end
    end
  end

  // Array is not reset; writes are gated by state, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= ad_in;
    end
  end

`ifdef MC_STATS_EN
  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      rd_bursts <= '0;
      wr_bursts <= '0;
    end else if (accept) begin
      if (rw) begin
        if (rd_bursts != 16'hFFFF) rd_bursts <= rd_bursts + 16'd1;
      end else begin
        if (wr_bursts != 16'hFFFF) wr_bursts <= wr_bursts + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mc_burst_ctrl.sv
// Directed bench for mc_burst_ctrl: three instances (pages 0, 1, 2) on one bus.
module tb_mc_burst_ctrl;

  logic        clk;
  logic        resetL;
  logic        addr_valid;
  logic        rw;
  logic [15:0] ad_in;

  logic [15:0] ad_out0, ad_out1, ad_out2;
  logic        ad_oe0, ad_oe1, ad_oe2;
  logic        busy0, busy1, busy2;
`ifdef MC_STATS_EN
  logic [15:0] rd_b0, wr_b0, rd_b1, wr_b1, rd_b2, wr_b2;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] cap [4];
  int          cap_n, cap_first, cap_last;

  mc_burst_ctrl #(.DATA_W(16), .PAGE_BITS(4), .PAGE_ID(0), .BURST_LEN(4)) u0 (
    .clk(clk), .resetL(resetL), .addr_valid(addr_valid), .rw(rw), .ad_in(ad_in),
`ifdef MC_STATS_EN
    .rd_bursts(rd_b0), .wr_bursts(wr_b0),
`endif
    .ad_out(ad_out0), .ad_oe(ad_oe0), .busy(busy0)
  );

  mc_burst_ctrl #(.DATA_W(16), .PAGE_BITS(4), .PAGE_ID(1), .BURST_LEN(4)) u1 (
    .clk(clk), .resetL(resetL), .addr_valid(addr_valid), .rw(rw), .ad_in(ad_in),
`ifdef MC_STATS_EN
    .rd_bursts(rd_b1), .wr_bursts(wr_b1),
`endif
    .ad_out(ad_out1), .ad_oe(ad_oe1), .busy(busy1)
  );

  mc_burst_ctrl #(.DATA_W(16), .PAGE_BITS(4), .PAGE_ID(2), .BURST_LEN(4)) u2 (
    .clk(clk), .resetL(resetL), .addr_valid(addr_valid), .rw(rw), .ad_in(ad_in),
`ifdef MC_STATS_EN
    .rd_bursts(rd_b2), .wr_bursts(wr_b2),
`endif
    .ad_out(ad_out2), .ad_oe(ad_oe2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] d0,
                          input logic [15:0] d1, input logic [15:0] d2,
                          input logic [15:0] d3);
    addr_valid = 1'b1; rw = 1'b0; ad_in = addr;
    tick;
    addr_valid = 1'b0;
    ad_in = d0; tick;
    ad_in = d1; tick;
    ad_in = d2; tick;
    ad_in = d3; tick;
    ad_in = '0;
  endtask

  // Issues a read to page 2 and records every word seen with ad_oe2 high.
  task automatic capture_read(input logic [15:0] addr);
    addr_valid = 1'b1; rw = 1'b1; ad_in = addr;
    tick;
    addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
    cap_n = 0; cap_first = 0; cap_last = 0;
    for (int c = 1; c <= 8; c++) begin
      if (ad_oe2) begin
        if (cap_n < 4) cap[cap_n] = ad_out2;
        if (cap_first == 0) cap_first = c;
        cap_last = c;
        cap_n++;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    resetL = 1'b0; addr_valid = 1'b1; rw = 1'b0; ad_in = 16'h2000;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (busy2 !== 1'b0) begin
        errors++; $display("FAIL reset_busy2: got %b expected 0", busy2);
      end
      checks++;
      if (ad_oe2 !== 1'b0) begin
        errors++; $display("FAIL reset_oe2: got %b expected 0", ad_oe2);
      end
    end
    resetL = 1'b1; addr_valid = 1'b0; ad_in = '0;
    tick;
    checks++;
    if ({busy0, busy1, busy2} !== 3'b000) begin
      errors++; $display("FAIL post_reset_busy: got %b expected 000", {busy0, busy1, busy2});
    end
    checks++;
    if ({ad_oe0, ad_oe1, ad_oe2} !== 3'b000) begin
      errors++; $display("FAIL post_reset_oe: got %b expected 000", {ad_oe0, ad_oe1, ad_oe2});
    end
    checks++;
    if (ad_out2 !== 16'h0000) begin
      errors++; $display("FAIL post_reset_ad_out: got %h expected 0000", ad_out2);
    end
  endtask

  task automatic test_write_read;
    logic [15:0] dat [4];
    dat[0] = 16'hA0A0; dat[1] = 16'hA1A1; dat[2] = 16'hA2A2; dat[3] = 16'hA3A3;
    // Neighbouring block, used later to show the wrap never leaves its block.
    do_write(16'h2014, 16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3);

    addr_valid = 1'b1; rw = 1'b0; ad_in = 16'h2010;
    tick;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL wr_busy_start: got %b expected 1", busy2);
    end
    addr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ad_in = dat[k];
      tick;
      checks++;
      if (busy2 !== (k < 3)) begin
        errors++; $display("FAIL wr_busy_beat%0d: got %b expected %b", k, busy2, (k < 3));
      end
    end
    ad_in = '0;
    checks++;
    if (ad_oe2 !== 1'b0) begin
      errors++; $display("FAIL pre_read_oe: got %b expected 0", ad_oe2);
    end

    addr_valid = 1'b1; rw = 1'b1; ad_in = 16'h2010;
    tick;
    addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ad_oe2 !== 1'b1) begin
        errors++; $display("FAIL rd_oe_word%0d: got %b expected 1", k, ad_oe2);
      end
      checks++;
      if (ad_out2 !== dat[k]) begin
        errors++; $display("FAIL rd_data_word%0d: got %h expected %h", k, ad_out2, dat[k]);
      end
      tick;
    end
    checks++;
    if (ad_oe2 !== 1'b0) begin
      errors++; $display("FAIL rd_oe_end: got %b expected 0", ad_oe2);
    end
    checks++;
    if (busy2 !== 1'b0) begin
      errors++; $display("FAIL rd_busy_end: got %b expected 0", busy2);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_w [4];
    logic [15:0] exp_n [4];
    exp_w[0] = 16'hA2A2; exp_w[1] = 16'hA3A3; exp_w[2] = 16'hA0A0; exp_w[3] = 16'hA1A1;
    exp_n[0] = 16'hB0B0; exp_n[1] = 16'hB1B1; exp_n[2] = 16'hB2B2; exp_n[3] = 16'hB3B3;
    capture_read(16'h2012);
    checks++;
    if (cap_n !== 4 || cap_first !== 1 || cap_last !== 4) begin
      errors++;
      $display("FAIL wrap_oe_window: got n=%0d first=%0d last=%0d expected 4 1 4",
               cap_n, cap_first, cap_last);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap[k] !== exp_w[k]) begin
        errors++; $display("FAIL wrap_word%0d: got %h expected %h", k, cap[k], exp_w[k]);
      end
    end
    capture_read(16'h2014);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap[k] !== exp_n[k]) begin
        errors++; $display("FAIL neighbour_word%0d: got %h expected %h", k, cap[k], exp_n[k]);
      end
    end
  endtask

  task automatic test_page_filter;
    logic [15:0] dat [4];
    dat[0] = 16'hC0C0; dat[1] = 16'hC1C1; dat[2] = 16'hC2C2; dat[3] = 16'hC3C3;
    addr_valid = 1'b1; rw = 1'b0; ad_in = 16'h1005;
    tick;
    checks++;
    if ({busy0, busy1, busy2} !== 3'b010) begin
      errors++; $display("FAIL page_wr_busy: got %b expected 010", {busy0, busy1, busy2});
    end
    addr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ad_in = dat[k];
      tick;
      checks++;
      if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
        errors++; $display("FAIL page_wr_other_busy%0d: got %b%b expected 00", k, busy0, busy2);
      end
    end
    // Readback from page 1: offsets 005,006,007,004 in write order.
    addr_valid = 1'b1; rw = 1'b1; ad_in = 16'h1005;
    tick;
    addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ad_oe1 !== 1'b1 || ad_out1 !== dat[k]) begin
        errors++;
        $display("FAIL page1_rd_word%0d: got oe=%b %h expected oe=1 %h", k, ad_oe1, ad_out1, dat[k]);
      end
      tick;
    end
    addr_valid = 1'b1; rw = 1'b1; ad_in = 16'h3005;
    tick;
    addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({ad_oe0, ad_oe1, ad_oe2, busy0, busy1, busy2} !== 6'b0) begin
        errors++;
        $display("FAIL page3_ignored%0d: got oe=%b%b%b busy=%b%b%b expected all 0",
                 c, ad_oe0, ad_oe1, ad_oe2, busy0, busy1, busy2);
      end
      tick;
    end
  endtask

  task automatic test_mid_reset;
    logic [15:0] exp_m [4];
    exp_m[0] = 16'hE0E0; exp_m[1] = 16'hE1E1; exp_m[2] = 16'hD2D2; exp_m[3] = 16'hD3D3;
    do_write(16'h2040, 16'hD0D0, 16'hD1D1, 16'hD2D2, 16'hD3D3);
    addr_valid = 1'b1; rw = 1'b0; ad_in = 16'h2040;
    tick;
    addr_valid = 1'b0;
    ad_in = 16'hE0E0; tick;
    ad_in = 16'hE1E1; tick;
    ad_in = 16'hE2E2;
    checks++;
    if (busy2 !== 1'b1) begin
      errors++; $display("FAIL midwr_busy_before: got %b expected 1", busy2);
    end
    #3 resetL = 1'b0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || ad_oe2 !== 1'b0) begin
      errors++; $display("FAIL midwr_async_clear: got busy=%b oe=%b expected 0 0", busy2, ad_oe2);
    end
    tick;
    resetL = 1'b1; ad_in = 16'hE3E3;
    tick;
    ad_in = '0;
    capture_read(16'h2040);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap[k] !== exp_m[k]) begin
        errors++; $display("FAIL midwr_word%0d: got %h expected %h", k, cap[k], exp_m[k]);
      end
    end
    // Reset in the middle of a read burst.
    addr_valid = 1'b1; rw = 1'b1; ad_in = 16'h2010;
    tick;
    addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
    tick;
    checks++;
    if (ad_oe2 !== 1'b1) begin
      errors++; $display("FAIL midrd_oe_before: got %b expected 1", ad_oe2);
    end
    #3 resetL = 1'b0;
    #1;
    checks++;
    if (busy2 !== 1'b0 || ad_oe2 !== 1'b0) begin
      errors++; $display("FAIL midrd_async_clear: got busy=%b oe=%b expected 0 0", busy2, ad_oe2);
    end
    tick;
    resetL = 1'b1;
    tick;
  endtask

  // R 2010, R 2014, R 2040, W 2060, W 2070 with no idle cycle. The final write
  // beat of W 2060 shares its edge with the W 2070 address on the multiplexed
  // bus, so that beat's data word is 16'h2070.
  task automatic test_back_to_back;
    logic [15:0] rd_exp [12];
    logic [15:0] e2060 [4];
    logic [15:0] e2070 [4];
    rd_exp[0] = 16'hA0A0; rd_exp[1]  = 16'hA1A1; rd_exp[2]  = 16'hA2A2; rd_exp[3]  = 16'hA3A3;
    rd_exp[4] = 16'hB0B0; rd_exp[5]  = 16'hB1B1; rd_exp[6]  = 16'hB2B2; rd_exp[7]  = 16'hB3B3;
    rd_exp[8] = 16'hE0E0; rd_exp[9]  = 16'hE1E1; rd_exp[10] = 16'hD2D2; rd_exp[11] = 16'hD3D3;
    e2060[0] = 16'h6A00; e2060[1] = 16'h6A01; e2060[2] = 16'h6A02; e2060[3] = 16'h2070;
    e2070[0] = 16'h7B00; e2070[1] = 16'h7B01; e2070[2] = 16'h7B02; e2070[3] = 16'h7B03;

    resetL = 1'b0; tick; resetL = 1'b1; tick;
    for (int c = 0; c <= 20; c++) begin
      addr_valid = (c == 0 || c == 4 || c == 8 || c == 12 || c == 16);
      rw = (c < 12);
      case (c)
        0:       ad_in = 16'h2010;
        4:       ad_in = 16'h2014;
        8:       ad_in = 16'h2040;
        12:      ad_in = 16'h2060;
        13:      ad_in = 16'h6A00;
        14:      ad_in = 16'h6A01;
        15:      ad_in = 16'h6A02;
        16:      ad_in = 16'h2070;
        17:      ad_in = 16'h7B00;
        18:      ad_in = 16'h7B01;
        19:      ad_in = 16'h7B02;
        20:      ad_in = 16'h7B03;
        default: ad_in = 16'h0000;
      endcase
      tick;
      checks++;
      if (ad_oe2 !== (c < 12)) begin
        errors++; $display("FAIL b2b_oe_cyc%0d: got %b expected %b", c + 1, ad_oe2, (c < 12));
      end
      if (c < 12) begin
        checks++;
        if (ad_out2 !== rd_exp[c]) begin
          errors++; $display("FAIL b2b_data_cyc%0d: got %h expected %h", c + 1, ad_out2, rd_exp[c]);
        end
      end
      checks++;
      if (busy2 !== (c < 20)) begin
        errors++; $display("FAIL b2b_busy_cyc%0d: got %b expected %b", c + 1, busy2, (c < 20));
      end
    end
    addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
`ifdef MC_STATS_EN
    checks++;
    if (rd_b2 !== 16'd3) begin
      errors++; $display("FAIL stats_rd: got %0d expected 3", rd_b2);
    end
    checks++;
    if (wr_b2 !== 16'd2) begin
      errors++; $display("FAIL stats_wr: got %0d expected 2", wr_b2);
    end
`endif
    capture_read(16'h2060);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap[k] !== e2060[k]) begin
        errors++; $display("FAIL b2b_w2060_word%0d: got %h expected %h", k, cap[k], e2060[k]);
      end
    end
    capture_read(16'h2070);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cap[k] !== e2070[k]) begin
        errors++; $display("FAIL b2b_w2070_word%0d: got %h expected %h", k, cap[k], e2070[k]);
      end
    end
  endtask

  initial begin
    resetL = 1'b0; addr_valid = 1'b0; rw = 1'b0; ad_in = '0;
    test_reset;
    test_write_read;
    test_wrap;
    test_page_filter;
    test_mid_reset;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
